// File: rtl/counter163_ctrl.sv
// Sequencing master for a 4-bit 163-style counter.
// Runs modulo START_VAL..TERM_VAL periods and checks Q/RCO against a shadow count.
module counter163_ctrl #(
  parameter int PER_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [3:0]       START_VAL,
  input  logic [3:0]       TERM_VAL,
  input  logic [PER_W-1:0] NPER,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             CLR_N,
  output logic             LOAD_N,
  output logic             EN,
  input  logic             QA,
  input  logic             QB,
  input  logic             QC,
  input  logic             QD,
  input  logic             RCO,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [PER_W-1:0] PER_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [3:0]       sv_q;
  logic [3:0]       tv_q;
  logic [PER_W-1:0] nper_q;
  logic [3:0]       exp_q;
  logic [3:0]       exp_nx;
  logic [PER_W-1:0] per_nx;
  logic [PER_W-1:0] per_inc;
  logic [3:0]       q;
  logic [3:0]       pre;
  logic             at_term;
  logic             exp_term;
  logic             accept;
  logic             chk;

  assign q        = {QD, QC, QB, QA};
  assign at_term  = q == tv_q;
  assign exp_term = exp_q == tv_q;
  assign per_inc  = PER_CNT + PER_W'(1);
  assign accept   = (state == S_IDLE) && START;
  assign {D, C, B, A} = pre;

  always_comb begin
    state_nx = state;
    exp_nx   = exp_q;
    per_nx   = PER_CNT;
    CLR_N    = 1'b1;
    LOAD_N   = 1'b1;
    EN       = 1'b0;
    pre      = 4'd0;
    BUSY     = state != S_IDLE;
    DONE     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          state_nx = S_CLEAR;
          per_nx   = '0;
        end
      end
      S_CLEAR: begin
        CLR_N    = 1'b0;
        exp_nx   = 4'd0;
        state_nx = S_PRESET;
      end
      S_PRESET: begin
        LOAD_N   = 1'b0;
        pre      = sv_q;
        exp_nx   = sv_q;
        state_nx = S_RUN;
      end
      S_RUN: begin
        EN = 1'b1;
        // reload is driven from the returned count, not the shadow
        if (at_term) begin
          LOAD_N = 1'b0;
          pre    = sv_q;
        end
        if (exp_term) begin
          exp_nx = sv_q;
          per_nx = per_inc;
          if (nper_q != '0 && per_inc == nper_q)
            state_nx = S_DONE;
        end else begin
          exp_nx = exp_q + 4'd1;
        end
      end
      S_DONE: begin
        DONE     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (ABORT && state != S_IDLE) begin
      state_nx = S_IDLE;
      exp_nx   = exp_q;
      per_nx   = PER_CNT;
    end
  end

  assign chk = (state == S_RUN || state == S_DONE) &&
               (q != exp_q || RCO != (EN && q == 4'hF));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      exp_q   <= 4'd0;
      PER_CNT <= '0;
      ERR     <= 1'b0;
      sv_q    <= 4'd0;
      tv_q    <= 4'd0;
      nper_q  <= '0;
    end else begin
      state   <= state_nx;
      exp_q   <= exp_nx;
      PER_CNT <= per_nx;
      if (accept) begin
        ERR    <= 1'b0;
        sv_q   <= START_VAL;
        tv_q   <= TERM_VAL;
        nper_q <= NPER;
      end else if (chk) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule
